// File: rtl/gcd_stream.sv
// Streaming binary (Stein) GCD engine with valid/ready on both sides.
// Latency: 1 edge for a zero operand, else N+1 edges (N CALC steps, N <= 2*WIDTH).
// Backpressure: result holds in DONE until out_ready; no new pair is taken while busy.
module gcd_stream #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic [2*WIDTH-1:0] in_data,
    output logic               in_ready,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data
);
    localparam int KW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_r, b_r, res;
    logic [WIDTH-1:0] a_nxt, b_nxt, res_nxt;
    logic [KW-1:0]    k, k_nxt;
    logic [WIDTH-1:0] a_in, b_in;
    logic             accept;
    logic             zero_in;

    assign a_in    = in_data[2*WIDTH-1:WIDTH];
    assign b_in    = in_data[WIDTH-1:0];
    assign accept  = in_valid && in_ready;
    assign zero_in = (a_in == '0) || (b_in == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (zero_in) state_nxt = DONE;
                    else         state_nxt = CALC;
                end
            end
            CALC: begin
                if (a_r == b_r) state_nxt = DONE;
            end
            DONE: begin
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // One Stein step per cycle; the first matching rule wins.
    always_comb begin
        a_nxt   = a_r;
        b_nxt   = b_r;
        k_nxt   = k;
        res_nxt = res;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (zero_in) begin
                        res_nxt = a_in | b_in;
                    end else begin
                        a_nxt = a_in;
                        b_nxt = b_in;
                        k_nxt = '0;
                    end
                end
            end
            CALC: begin
                if (a_r == b_r) begin
                    res_nxt = a_r << k;
                end else if (!a_r[0] && !b_r[0]) begin
                    a_nxt = a_r >> 1;
                    b_nxt = b_r >> 1;
                    k_nxt = k + KW'(1);
                end else if (!a_r[0]) begin
                    a_nxt = a_r >> 1;
                end else if (!b_r[0]) begin
                    b_nxt = b_r >> 1;
                end else if (a_r > b_r) begin
                    a_nxt = (a_r - b_r) >> 1;
                end else begin
                    b_nxt = (b_r - a_r) >> 1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_r <= '0;
            b_r <= '0;
            k   <= '0;
            res <= '0;
        end else begin
            a_r <= a_nxt;
            b_r <= b_nxt;
            k   <= k_nxt;
            res <= res_nxt;
        end
    end

    // in_ready is gated by reset directly so it falls without waiting for an edge.
    always_comb begin
        in_ready  = (state == IDLE) && !reset;
        out_valid = (state == DONE);
        out_data  = res;
    end
endmodule

// File: tb/tb_gcd_stream.sv
// Directed and randomized bench for gcd_stream at WIDTH=16 and WIDTH=32.
module tb_gcd_stream;
    logic        clk;
    logic        rst16, iv16, ir16, ov16, or16;
    logic [31:0] id16;
    logic [15:0] od16;
    logic        rst32, iv32, ir32, ov32, or32;
    logic [63:0] id32;
    logic [31:0] od32;

    int checks   = 0;
    int failures = 0;

    gcd_stream #(.WIDTH(16)) dut16 (
        .clk(clk), .reset(rst16), .in_valid(iv16), .in_data(id16), .in_ready(ir16),
        .out_valid(ov16), .out_ready(or16), .out_data(od16)
    );

    gcd_stream #(.WIDTH(32)) dut32 (
        .clk(clk), .reset(rst32), .in_valid(iv32), .in_data(id32), .in_ready(ir32),
        .out_valid(ov32), .out_ready(or32), .out_data(od32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] gcd_ref(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    // Called at a falling edge; returns at the falling edge where out_valid is seen.
    // lat counts rising edges from the accept edge inclusive.
    task automatic issue16(input logic [31:0] d, input bit keep_valid, output int lat);
        iv16 = 1'b1;
        id16 = d;
        #1;
        check("in_ready_idle16", ir16, 1'b1);
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        if (!keep_valid) iv16 = 1'b0;
        while (!ov16 && lat < 200) begin
            check("in_ready_busy16", ir16, 1'b0);
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check("done_in_budget16", ov16, 1'b1);
    endtask

    task automatic pop16();
        or16 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        or16 = 1'b0;
        check("out_valid_after_pop16", ov16, 1'b0);
        check("in_ready_after_pop16", ir16, 1'b1);
    endtask

    task automatic issue32(input logic [63:0] d, output int lat);
        iv32 = 1'b1;
        id32 = d;
        #1;
        check("in_ready_idle32", ir32, 1'b1);
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        iv32 = 1'b0;
        while (!ov32 && lat < 200) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check("done_in_budget32", ov32, 1'b1);
    endtask

    task automatic pop32();
        or32 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        or32 = 1'b0;
        check("out_valid_after_pop32", ov32, 1'b0);
    endtask

    initial begin
        int          lat;
        logic [31:0] a, b, g;
        logic [15:0] a16, b16;

        rst16 = 1'b1; rst32 = 1'b1;
        iv16 = 1'b1; id16 = 32'h0030_0020; or16 = 1'b0;
        iv32 = 1'b0; id32 = '0; or32 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_in_ready16", ir16, 1'b0);
        check("rst_out_valid16", ov16, 1'b0);
        check("rst_out_data16", od16, 16'h0);
        check("rst_in_ready32", ir32, 1'b0);
        check("rst_out_valid32", ov32, 1'b0);
        rst16 = 1'b0; rst32 = 1'b0;

        // in_valid already high at release: accepted on the first edge.
        issue16(32'h0030_0020, 1'b1, lat);
        check("basic_data", od16, 16'd16);
        check("basic_latency", lat, 8);
        iv16 = 1'b0;
        pop16();

        issue16(32'h0000_0015, 1'b0, lat);
        check("zero_a_data", od16, 16'h15);
        check("zero_a_latency", lat, 1);
        pop16();
        issue16(32'h0000_0000, 1'b0, lat);
        check("zero_both_data", od16, 16'h0);
        pop16();
        issue16(32'h0007_0000, 1'b0, lat);
        check("zero_b_data", od16, 16'h7);
        check("zero_b_latency", lat, 1);
        pop16();

        issue16(32'hFFFF_FFFE, 1'b0, lat);
        check("ffff_fffe_data", od16, 16'h1);
        pop16();
        issue16(32'hFFFF_FFFF, 1'b0, lat);
        check("ffff_ffff_data", od16, 16'hFFFF);
        check("ffff_ffff_latency", lat, 2);
        pop16();
        issue16(32'h8000_4000, 1'b0, lat);
        check("pow2_data", od16, 16'h4000);
        pop16();

        // Backpressure with a new pair waiting on in_valid.
        issue16(32'h0030_0020, 1'b0, lat);
        iv16 = 1'b1;
        id16 = 32'h000C_0012;
        for (int i = 0; i < 5; i++) begin
            check("bp_out_valid", ov16, 1'b1);
            check("bp_out_data", od16, 16'd16);
            check("bp_in_ready", ir16, 1'b0);
            @(posedge clk);
            @(negedge clk);
        end
        pop16();
        issue16(32'h000C_0012, 1'b0, lat);
        check("bp_pending_data", od16, 16'd6);
        pop16();

        // Reset in the third CALC cycle.
        iv16 = 1'b1;
        id16 = 32'h0030_0020;
        @(posedge clk);
        #1 iv16 = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst16 = 1'b1;
        #1;
        check("rst_calc_out_valid", ov16, 1'b0);
        check("rst_calc_in_ready", ir16, 1'b0);
        @(negedge clk);
        rst16 = 1'b0;
        #1;
        check("rst_calc_release_in_ready", ir16, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_calc_no_stale", ov16, 1'b0);
        end
        issue16(32'h0030_0020, 1'b0, lat);
        check("rst_calc_fresh_data", od16, 16'd16);
        check("rst_calc_fresh_latency", lat, 8);
        pop16();

        // Reset while a result is waiting in DONE.
        issue16(32'h0000_0015, 1'b0, lat);
        #2 rst16 = 1'b1;
        #1;
        check("rst_done_out_valid", ov16, 1'b0);
        check("rst_done_out_data", od16, 16'h0);
        @(negedge clk);
        rst16 = 1'b0;
        @(negedge clk);
        check("rst_done_no_stale", ov16, 1'b0);

        for (int n = 0; n < 100; n++) begin
            case ($urandom_range(0, 2))
                0: begin a16 = 16'($urandom); b16 = 16'($urandom); end
                1: begin a16 = 16'($urandom_range(0, 20)); b16 = 16'($urandom_range(0, 20)); end
                default: begin
                    g   = 32'($urandom_range(1, 255));
                    a16 = 16'(g * 32'($urandom_range(0, 255)));
                    b16 = 16'(g * 32'($urandom_range(0, 255)));
                end
            endcase
            issue16({a16, b16}, 1'b0, lat);
            check("rand16_data", od16, 16'(gcd_ref({16'h0, a16}, {16'h0, b16})));
            check("rand16_calc_bound", (lat - 1) <= 32, 1'b1);
            pop16();
        end

        issue32({32'h8000_0000, 32'h0000_0040}, lat);
        check("w32_pow2_data", od32, 32'h40);
        pop32();

        for (int n = 0; n < 1000; n++) begin
            case ($urandom_range(0, 3))
                0, 1: begin a = $urandom; b = $urandom; end
                2: begin a = $urandom_range(0, 20); b = $urandom_range(0, 20); end
                default: begin
                    g = $urandom_range(1, 65535) << $urandom_range(0, 8);
                    a = g * $urandom_range(0, 65535);
                    b = g * $urandom_range(0, 65535);
                end
            endcase
            issue32({a, b}, lat);
            check("rand32_data", od32, gcd_ref(a, b));
            check("rand32_calc_bound", (lat - 1) <= 64, 1'b1);
            pop32();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
